// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam int WORD_BYTES = 4;
    localparam int PC_W       = 32;
    localparam int ENTRY_W    = 2 * PC_W;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with a single-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [ENTRY_W-1:0]       entry_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [ENTRY_W-1:0]       entry_o,
    output logic [$clog2(DEPTH):0]   count_next_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               push_ok;
    logic               pop_ok;

    assign push_ok = push_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    // Flush wins over any push or pop happening in the same cycle.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push_ok) begin
                    mem_q[wr_q] <= entry_i;
                    wr_q        <= wr_q + AW'(1);
                end
                if (pop_ok) begin
                    rd_q <= rd_q + AW'(1);
                end
            end
        end
    end

    assign valid_o      = (count_q != '0);
    assign entry_o      = mem_q[rd_q];
    assign count_next_o = count_d;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: tracks the fetch PC, issues one word read at a time and
// buffers returned instructions with their PCs for the decode stage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int           DEPTH    = 4,
    parameter logic [31:0]  RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        except
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               mem_req_q, mem_req_d;
    logic [PC_W-3:0]    mem_addr_q, mem_addr_d;
    logic               except_q, except_d;

    logic               ack_valid;
    logic               flush;
    logic               push;
    logic               pop;
    logic               room;
    logic [CW-1:0]      count_next;
    logic [PC_W-1:0]    pc_next_seq;
    logic [ENTRY_W-1:0] head;

    assign ack_valid   = mem_ack && mem_req_q;
    assign flush       = redirect && (state_q != HALT);
    assign push        = ack_valid && (state_q == FETCH) && !flush;
    assign pop         = inst_valid && inst_ready;
    assign room        = (count_next < CW'(DEPTH));
    assign pc_next_seq = fetch_pc_q + PC_W'(WORD_BYTES);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset),
        .flush_i      (flush),
        .push_i       (push),
        .entry_i      ({fetch_pc_q, mem_rdata}),
        .pop_i        (pop),
        .valid_o      (inst_valid),
        .entry_o      (head),
        .count_next_o (count_next)
    );

    // A raised request holds its address until acked; a redirect only
    // takes over the request slot once nothing is left in flight.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        except_d   = except_q;

        case (state_q)
            FETCH: begin
                if (ack_valid) begin
                    fetch_pc_d = pc_next_seq;
                    mem_req_d  = room;
                    mem_addr_d = pc_next_seq[PC_W-1:2];
                end else if (!mem_req_q) begin
                    mem_req_d  = room;
                    mem_addr_d = fetch_pc_q[PC_W-1:2];
                end
            end
            DRAIN: begin
                if (ack_valid) begin
                    state_d    = FETCH;
                    mem_req_d  = room;
                    mem_addr_d = fetch_pc_q[PC_W-1:2];
                end
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase

        if (flush) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_d   = HALT;
                except_d  = 1'b1;
                mem_req_d = 1'b0;
            end else begin
                fetch_pc_d = redirect_pc;
                if (mem_req_q && !mem_ack) begin
                    state_d    = DRAIN;
                    mem_req_d  = 1'b1;
                    mem_addr_d = mem_addr_q;
                end else begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = redirect_pc[PC_W-1:2];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC[PC_W-1:2];
            except_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            except_q   <= except_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign except   = except_q;
    assign inst     = head[PC_W-1:0];
    assign inst_pc  = head[ENTRY_W-1:PC_W];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-level reference model and a
// latency-programmable instruction memory responder.
module tb_fetch_queue;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          M_FETCH = 0;
    localparam int          M_DRAIN = 1;
    localparam int          M_HALT  = 2;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        except;

    int checks;
    int failures;
    int latency;
    int waitCnt;
    int reqCycles;

    logic [63:0] mq[$];
    logic [31:0] mPc;
    logic        mReq;
    logic [29:0] mAddr;
    int          mMode;
    logic        mExcept;
    logic        ackSeen;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .except      (except)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memWord(input logic [29:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redir, input logic [31:0] pc);
        #1;
        redirect    = redir;
        redirect_pc = pc;
    endtask

    task automatic doReset(input int lat, input logic ready);
        @(negedge clock);
        #1;
        reset      = 1'b0;
        redirect   = 1'b0;
        latency    = lat;
        inst_ready = ready;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Memory answers a held request after `latency` cycles of it being up.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        waitCnt   = 0;
    end
    always @(negedge clock) begin
        #2;
        if (!reset || !mem_req) begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end else begin
            waitCnt++;
            mem_ack   = (waitCnt >= latency);
            mem_rdata = memWord(mem_addr);
            if (mem_ack) waitCnt = 0;
        end
    end

    // Reference model: instruction queue plus the outstanding request.
    initial begin
        mPc     = TB_RESET_PC;
        mReq    = 1'b0;
        mAddr   = TB_RESET_PC[31:2];
        mMode   = M_FETCH;
        mExcept = 1'b0;
    end
    always @(posedge clock) begin
        if (!reset) begin
            mq.delete();
            mPc     = TB_RESET_PC;
            mReq    = 1'b0;
            mAddr   = TB_RESET_PC[31:2];
            mMode   = M_FETCH;
            mExcept = 1'b0;
        end else begin
            ackSeen = mem_ack && mReq;
            if (mMode != M_HALT && redirect) begin
                mq.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    mMode   = M_HALT;
                    mExcept = 1'b1;
                    mReq    = 1'b0;
                end else begin
                    mPc = redirect_pc;
                    if (mReq && !mem_ack) begin
                        mMode = M_DRAIN;
                    end else begin
                        mMode = M_FETCH;
                        mReq  = 1'b1;
                        mAddr = redirect_pc[31:2];
                    end
                end
            end else if (mMode == M_FETCH) begin
                if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
                if (ackSeen) begin
                    mq.push_back({mPc, mem_rdata});
                    mPc = mPc + 32'd4;
                end
                if (ackSeen || !mReq) begin
                    mReq  = (mq.size() < DEPTH);
                    mAddr = mPc[31:2];
                end
            end else if (mMode == M_DRAIN && ackSeen) begin
                mMode = M_FETCH;
                mReq  = 1'b1;
                mAddr = mPc[31:2];
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            checkOutput("mdl_mem_req", mem_req, mReq);
            if (mReq) checkOutput("mdl_mem_addr", mem_addr, mAddr);
            checkOutput("mdl_inst_valid", inst_valid, mq.size() > 0);
            if (mq.size() > 0) begin
                checkOutput("mdl_inst_pc", inst_pc, mq[0][63:32]);
                checkOutput("mdl_inst", inst, mq[0][31:0]);
            end
            checkOutput("mdl_except", except, mExcept);
        end
    end

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        latency     = 1;
        #2 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst", inst, 0);
        checkOutput("rst_inst_pc", inst_pc, 0);
        checkOutput("rst_except", except, 0);

        $display("[TB] streaming fetch, single-cycle memory");
        doReset(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("t1_mem_req", mem_req, 1);
            checkOutput("t1_mem_addr", mem_addr, i);
            if (i > 0) checkOutput("t1_inst_pc", inst_pc, (i - 1) * 4);
        end
        @(negedge clock);
        checkOutput("t1_inst_pc", inst_pc, 32'hC);

        $display("[TB] back-pressure fills the queue");
        doReset(1, 1'b0);
        reqCycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_req) reqCycles++;
        end
        checkOutput("t2_req_count", reqCycles, 4);
        checkOutput("t2_req_low", mem_req, 0);
        checkOutput("t2_head_pc", inst_pc, 0);
        #1 inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clock);
            checkOutput("t2_seq_valid", inst_valid, 1);
            checkOutput("t2_seq_pc", inst_pc, i * 4);
        end

        $display("[TB] redirect while a slow read is in flight");
        doReset(3, 1'b1);
        @(negedge clock);
        checkOutput("t3_req_rise", mem_req, 1);
        @(negedge clock);
        applyStimulus(1'b1, 32'h40);
        @(negedge clock);
        checkOutput("t3_addr_held", mem_addr, 0);
        checkOutput("t3_req_held", mem_req, 1);
        applyStimulus(1'b0, 32'h0);
        @(negedge clock);
        checkOutput("t3_new_addr", mem_addr, 30'h10);
        checkOutput("t3_no_stale", inst_valid, 0);
        repeat (2) begin
            @(negedge clock);
            checkOutput("t3_no_stale", inst_valid, 0);
        end
        @(negedge clock);
        checkOutput("t3_valid", inst_valid, 1);
        checkOutput("t3_pc", inst_pc, 32'h40);
        checkOutput("t3_inst", inst, memWord(30'h10));

        $display("[TB] redirect coinciding with an ack");
        doReset(1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("t4_pre_valid", inst_valid, 1);
        applyStimulus(1'b1, 32'h100);
        @(negedge clock);
        checkOutput("t4_flushed", inst_valid, 0);
        checkOutput("t4_new_addr", mem_addr, 30'h40);
        applyStimulus(1'b0, 32'h0);
        @(negedge clock);
        checkOutput("t4_pc", inst_pc, 32'h100);
        checkOutput("t4_inst", inst, memWord(30'h40));

        $display("[TB] misaligned redirect halts");
        doReset(1, 1'b1);
        repeat (2) @(negedge clock);
        applyStimulus(1'b1, 32'h42);
        @(negedge clock);
        checkOutput("t5_except", except, 1);
        applyStimulus(1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clock);
            checkOutput("t5_halt_req", mem_req, 0);
            checkOutput("t5_halt_valid", inst_valid, 0);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5_async_except", except, 0);
        checkOutput("t5_async_req", mem_req, 0);

        $display("[TB] PC wrap at top of address space");
        doReset(1, 1'b1);
        @(negedge clock);
        applyStimulus(1'b1, 32'hFFFF_FFFC);
        @(negedge clock);
        checkOutput("t6_addr_top", mem_addr, 30'h3FFF_FFFF);
        applyStimulus(1'b0, 32'h0);
        @(negedge clock);
        checkOutput("t6_pc_top", inst_pc, 32'hFFFF_FFFC);
        checkOutput("t6_addr_wrap", mem_addr, 0);
        @(negedge clock);
        checkOutput("t6_pc_wrap", inst_pc, 32'h0);
        checkOutput("t6_busy_valid", inst_valid, 1);
        checkOutput("t6_busy_req", mem_req, 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("t6_async_valid", inst_valid, 0);
        checkOutput("t6_async_req", mem_req, 0);
        checkOutput("t6_async_addr", mem_addr, 0);
        checkOutput("t6_async_pc", inst_pc, 0);
        checkOutput("t6_async_inst", inst, 0);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end placed directly upstream of the decoder/register-file stage of the MIPS datapath. It tracks the fetch PC and issues word reads to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small FIFO, and the downstream stage pops them with a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new PC. Misaligned redirect targets raise `except`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `redirect`, in, 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`, in, 32: new fetch PC; sampled when `redirect`=1.
- `mem_req`, out, 1: read request to instruction memory.
- `mem_addr`, out, 30: word address (PC[31:2]).
- `mem_ack`, in, 1: read complete; `mem_rdata` valid this cycle.
- `mem_rdata`, in, 32: instruction word.
- `inst_valid`, out, 1: queue head is valid.
- `inst`, out, 32: head instruction.
- `inst_pc`, out, 32: head PC.
- `inst_ready`, in, 1: consumer pops the head when `inst_valid`&`inst_ready`.
- `except`, out, 1: sticky; misaligned redirect target.

## Operation
- States: FETCH, DRAIN, HALT.
- Reset values: state=FETCH, `fetch_pc`=`RESET_PC`, FIFO empty, `mem_req`=0, `mem_addr`=`RESET_PC`[31:2], `inst_valid`=0, `inst`=0, `inst_pc`=0, `except`=0.
- FETCH:
  - `mem_req` = (count < `DEPTH`); `mem_addr` = `fetch_pc`[31:2].
  - On `mem_ack`: push {`fetch_pc`, `mem_rdata`} and set `fetch_pc` += 4 (wraps modulo 2^32).
- Request rules:
  - At most one request is outstanding.
  - Once asserted, `mem_req` and `mem_addr` stay stable until `mem_ack`; a request is never withdrawn.
  - `mem_ack` while `mem_req`=0 is ignored.
- Redirect (any state except HALT):
  - Flush the FIFO (count=0, `inst_valid`=0 next cycle).
  - A pop in the same cycle is discarded.
  - If `redirect_pc`[1:0]≠0: go to HALT and set `except`=1.
  - Otherwise load `fetch_pc`=`redirect_pc`.
  - If `mem_req`=1 and `mem_ack`=0 that cycle: go to DRAIN, keeping the old `mem_addr`.
  - If `mem_ack`=1 in the redirect cycle: discard the data and go to FETCH at the new PC.
- DRAIN:
  - `mem_req` stays 1 with the old address.
  - On `mem_ack`: discard the data and go to FETCH.
  - A further redirect in DRAIN updates `fetch_pc` only.
- HALT: `mem_req`=0, `inst_valid`=0, `except` held at 1. Leave only by reset.
- Push and pop in the same cycle: count unchanged. A full FIFO cannot receive an ack because no request is issued at count=`DEPTH`.
- Count arithmetic: pointers are log2(`DEPTH`) bits and wrap; count is log2(`DEPTH`)+1 bits.

## Timing
- First `mem_req` appears in the first cycle after `reset` deasserts.
- Ack at edge N: the entry is visible at `inst_valid` in cycle N+1. There is no empty-queue bypass.
- With single-cycle ack and `inst_ready`=1, sustained throughput is 1 instruction per cycle.
- Back-to-back requests: the cycle after an ack, `mem_req`=1 with address +4 if count<`DEPTH`.
- Redirect at edge R with no pending request: `mem_req` with the new address in cycle R+1.
- In the DRAIN case, the new-address request starts the cycle after the draining ack.
- `inst`/`inst_pc` read combinationally from FIFO storage at the read pointer. They are don't-care when `inst_valid`=0, but reset to 0.

## Structure
- Shared package `fetch_pkg`: state enum (FETCH, DRAIN, HALT), `WORD_BYTES`=4, `PC_W`=32.
- Sub-module `fetch_fifo`: parameterised sync FIFO with flush, async active-low reset, and 64-bit entries {pc, inst}.
- Top level holds the FSM, `fetch_pc`, and the request logic.

## Test plan
- Reset, then ack every cycle with `inst_ready`=1 -> addresses 0,1,2,3 on `mem_addr`; `inst_pc` 0,4,8,C one per cycle from the 3rd cycle after reset release.
- `inst_ready`=0 with single-cycle acks -> exactly `DEPTH`=4 requests, then `mem_req`=0; raise ready -> fetch resumes at `inst_pc`=0x10 with no lost or duplicate entries.
- Memory latency 3 cycles, `redirect` to 0x40 one cycle after `mem_req` rises -> `mem_addr` held at old value until ack; that data never appears; next request is addr 0x10 (PC 0x40).
- `redirect` and `mem_ack` in the same cycle, queue holding 2 entries -> queue empty next cycle; acked word dropped; next `inst_pc`=redirect target.
- `redirect_pc`=0x42 -> `except`=1 next cycle, `mem_req`/`inst_valid` stay 0 for 10 cycles; async reset mid-cycle clears all outputs immediately.
- Redirect to 0xFFFF_FFFC -> `inst_pc` 0xFFFF_FFFC then 0x0000_0000.
